// File: rtl/shot_sequencer_pkg.sv
// shot_sequencer_pkg: shared cell encodings, result codes and turn states
package shot_sequencer_pkg;
  typedef enum logic [2:0] {ARM_ROW, ARM_COL, FIRE, SETTLE, EVAL, DONE} state_t;
  localparam logic [1:0] WATER = 2'b00;
  localparam logic [1:0] SHIP = 2'b01;
  localparam logic [1:0] HIT = 2'b10;
  localparam logic [1:0] MISS = 2'b11;
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_HIT = 2'b01;
  localparam logic [1:0] RES_MISS = 2'b10;
  localparam logic [1:0] RES_REPEAT = 2'b11;
  function automatic logic [1:0] cell_at(input logic [31:0] cells, input logic [1:0] r, input logic [1:0] c);
    return cells[{r, c, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/shot_sequencer_onehot_to_idx.sv
// onehot_to_idx: 4-bit one-hot to 2-bit index with exactly-one-bit valid flag
module onehot_to_idx (
  input  logic [3:0] onehot,
  output logic [1:0] idx,
  output logic       valid
);
  assign idx = {onehot[3] | onehot[2], onehot[3] | onehot[1]};
  assign valid = (onehot != 4'd0) && ((onehot & (onehot - 4'd1)) == 4'd0);
endmodule

// File: rtl/shot_sequencer.sv
// shot_sequencer: arms a row then a column, fires one shot per turn and scores the cell readback
module shot_sequencer
  import shot_sequencer_pkg::*;
#(
  parameter int MAX_SHOTS = 10,
  parameter int SHIP_CELLS = 4,
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire_in,
  input  logic [3:0]  sel,
  input  logic        sel_error,
  input  logic        n_row,
  input  logic [31:0] cell_state,
  output logic [3:0]  row_en,
  output logic [3:0]  col_en,
  output logic        fire_out,
  output logic        busy,
  output logic [3:0]  shots,
  output logic [4:0]  hits,
  output logic [1:0]  last_result,
  output logic        fault,
  output logic        game_over,
  output logic        won
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [4:0] SHIPS = 5'(SHIP_CELLS);
  localparam logic [4:0] MAXS = 5'(MAX_SHOTS);
  state_t state;
  logic fire_q, ev, valid, row_ok, src_ok;
  logic [3:0] row_q, col_q, col_src, row_pick, col_pick, shots_nx;
  logic [1:0] ri, ci, tgt;
  logic [4:0] hits_nx;
  logic [CW-1:0] cnt;
  // while arming, the column index follows the live switches so the target can be inspected before firing
  assign col_src = (state == ARM_ROW || state == ARM_COL) ? sel : col_q;
  onehot_to_idx u_row (.onehot(row_q), .idx(ri), .valid(row_ok));
  onehot_to_idx u_col (.onehot(col_src), .idx(ci), .valid(src_ok));
  assign valid = src_ok && !sel_error;
  assign ev = fire_in && !fire_q;
  assign tgt = cell_at(cell_state, ri, ci);
  assign row_pick = (valid && !n_row) ? sel : 4'd0;
  assign col_pick = (valid && n_row) ? sel : 4'd0;
  assign shots_nx = (shots == 4'hF) ? shots : shots + 4'd1;
  assign hits_nx = (tgt == HIT && hits != 5'h1F) ? hits + 5'd1 : hits;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ARM_ROW;
      fire_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      cnt <= '0;
      row_en <= '0;
      col_en <= '0;
      fire_out <= 1'b0;
      busy <= 1'b0;
      shots <= '0;
      hits <= '0;
      last_result <= RES_NONE;
      fault <= 1'b0;
      game_over <= 1'b0;
      won <= 1'b0;
    end else begin
      fire_q <= fire_in;
      fire_out <= 1'b0;
      case (state)
        ARM_ROW: begin
          row_en <= row_pick;
          col_en <= '0;
          if (ev && valid && !n_row) begin
            row_q <= sel;
            state <= ARM_COL;
          end
        end
        ARM_COL: begin
          row_en <= (ev && valid && !n_row) ? sel : row_q;
          col_en <= col_pick;
          if (ev && valid && !n_row) row_q <= sel;
          else if (ev && valid && row_ok) begin
            col_q <= sel;
            if (tgt[1]) begin
              last_result <= RES_REPEAT;
              row_en <= '0;
              col_en <= '0;
              state <= ARM_ROW;
            end else begin
              fire_out <= 1'b1;
              busy <= 1'b1;
              state <= FIRE;
            end
          end
        end
        FIRE: begin
          cnt <= CW'(SETTLE);
          state <= shot_sequencer_pkg::SETTLE;
        end
        shot_sequencer_pkg::SETTLE: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= EVAL;
        end
        EVAL: begin
          shots <= shots_nx;
          hits <= hits_nx;
          busy <= 1'b0;
          last_result <= (tgt == HIT) ? RES_HIT : RES_MISS;
          if (!tgt[1]) fault <= 1'b1;
          if (hits_nx >= SHIPS || {1'b0, shots_nx} >= MAXS) begin
            state <= DONE;
            game_over <= 1'b1;
            won <= hits_nx >= SHIPS;
            row_en <= '0;
            col_en <= '0;
          end else begin
            state <= ARM_ROW;
            row_en <= row_pick;
            col_en <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_shot_sequencer.sv
// tb_shot_sequencer: randomized turn sequences scored against a shot-level game model
module tb_shot_sequencer;
  localparam int MAX_SHOTS = 10;
  localparam int SHIP_CELLS = 4;
  localparam int SETTLE = 2;
  logic clk = 1'b0, reset = 1'b0, fire_in = 1'b0, sel_error = 1'b0, n_row = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] grid = '0;
  logic [3:0] row_en, col_en, shots;
  logic [4:0] hits;
  logic [1:0] last_result;
  logic fire_out, busy, fault, game_over, won;
  int checks = 0, passed = 0;
  int m_shots, m_hits;
  logic [1:0] m_last;
  bit m_fault, m_over, m_won;
  int nf;

  always #5 clk = ~clk;

  shot_sequencer #(.MAX_SHOTS(MAX_SHOTS), .SHIP_CELLS(SHIP_CELLS), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .fire_in(fire_in), .sel(sel), .sel_error(sel_error),
    .n_row(n_row), .cell_state(grid), .row_en(row_en), .col_en(col_en), .fire_out(fire_out),
    .busy(busy), .shots(shots), .hits(hits), .last_result(last_result), .fault(fault),
    .game_over(game_over), .won(won)
  );

  task automatic model_clear();
    m_shots = 0; m_hits = 0; m_last = 2'b00; m_fault = 0; m_over = 0; m_won = 0;
  endtask

  task automatic restart(input logic [31:0] g);
    @(negedge clk); reset = 1'b0; fire_in = 1'b0; sel_error = 1'b0; grid = g;
    @(negedge clk); reset = 1'b1;
    model_clear();
  endtask

  task automatic press(input logic nr, input logic [3:0] s, input logic err, input int hold, output int cnt);
    cnt = 0;
    @(negedge clk); n_row = nr; sel = s; sel_error = err;
    @(negedge clk); fire_in = 1'b1;
    for (int k = 0; k < hold + 8; k++) begin
      @(negedge clk);
      if (k == hold - 1) fire_in = 1'b0;
      if (fire_out) cnt++;
    end
  endtask

  task automatic shoot(input int r, input int c, input bit stuck, input string tag);
    int idx, fires, hold, pn;
    logic [1:0] pre, post;
    logic [3:0] fr, fc;
    bit exp_fire;
    idx = 4 * r + c; fires = 0; fr = '0; fc = '0; hold = $urandom_range(1, 4);
    pre = grid[2*idx +: 2];
    exp_fire = !m_over && !pre[1];
    press(1'b0, 4'(1 << r), 1'b0, $urandom_range(1, 3), pn);
    @(negedge clk); n_row = 1'b1; sel = 4'(1 << c);
    @(negedge clk); fire_in = 1'b1;
    for (int k = 0; k < hold + 10; k++) begin
      @(negedge clk);
      if (k == hold - 1) fire_in = 1'b0;
      if (fire_out) begin
        fires++; fr = row_en; fc = col_en;
        if (!stuck) grid[2*idx +: 2] = pre[0] ? 2'b10 : 2'b11;
      end
    end
    if (!m_over) begin
      if (pre[1]) m_last = 2'b11;
      else begin
        post = stuck ? pre : (pre[0] ? 2'b10 : 2'b11);
        m_shots++;
        if (post == 2'b10) begin m_hits++; m_last = 2'b01; end
        else begin m_last = 2'b10; if (!post[1]) m_fault = 1; end
        if (m_hits >= SHIP_CELLS) begin m_over = 1; m_won = 1; end
        else if (m_shots >= MAX_SHOTS) m_over = 1;
      end
    end
    checks++; if (fires + pn !== (exp_fire ? 1 : 0)) $display("FAIL %s fire_count got %0d want %0d", tag, fires + pn, exp_fire); else passed++;
    if (exp_fire) begin
      checks++; if (fr !== 4'(1 << r)) $display("FAIL %s row_en got %b want %b", tag, fr, 4'(1 << r)); else passed++;
      checks++; if (fc !== 4'(1 << c)) $display("FAIL %s col_en got %b want %b", tag, fc, 4'(1 << c)); else passed++;
    end
    checks++; if (shots !== 4'(m_shots)) $display("FAIL %s shots got %0d want %0d", tag, shots, m_shots); else passed++;
    checks++; if (hits !== 5'(m_hits)) $display("FAIL %s hits got %0d want %0d", tag, hits, m_hits); else passed++;
    checks++; if (last_result !== m_last) $display("FAIL %s last_result got %b want %b", tag, last_result, m_last); else passed++;
    checks++; if (fault !== m_fault) $display("FAIL %s fault got %b want %b", tag, fault, m_fault); else passed++;
    checks++; if (game_over !== m_over) $display("FAIL %s game_over got %b want %b", tag, game_over, m_over); else passed++;
    checks++; if (won !== m_won) $display("FAIL %s won got %b want %b", tag, won, m_won); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL %s busy got %b want 0", tag, busy); else passed++;
  endtask

  task automatic test_reset();
    restart(32'h0000_0001);
    press(1'b0, 4'b0001, 1'b0, 1, nf);
    @(negedge clk); n_row = 1'b1; sel = 4'b0001;
    @(negedge clk); fire_in = 1'b1;
    @(negedge clk); grid[1:0] = 2'b10;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if ({row_en, col_en} !== 8'd0) $display("FAIL reset enables got %b want 0", {row_en, col_en}); else passed++;
    checks++; if ({fire_out, busy} !== 2'd0) $display("FAIL reset fire_busy got %b want 0", {fire_out, busy}); else passed++;
    checks++; if (shots !== 4'd0) $display("FAIL reset shots got %0d want 0", shots); else passed++;
    checks++; if (hits !== 5'd0) $display("FAIL reset hits got %0d want 0", hits); else passed++;
    checks++; if (last_result !== 2'b00) $display("FAIL reset last_result got %b want 00", last_result); else passed++;
    checks++; if ({fault, game_over, won} !== 3'd0) $display("FAIL reset flags got %b want 0", {fault, game_over, won}); else passed++;
    @(negedge clk); fire_in = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_clear();
    shoot(0, 0, 0, "abort_then_repeat");
  endtask

  task automatic test_hit();
    restart(32'h0000_1000);
    shoot(1, 2, 0, "hit_cell6");
  endtask

  task automatic test_repeat();
    shoot(1, 2, 0, "repeat_hit");
    checks++; if (row_en !== 4'd0) $display("FAIL repeat_arm_row row_en got %b want 0000", row_en); else passed++;
    restart(32'h0000_0C00);
    shoot(1, 1, 0, "repeat_miss");
  endtask

  task automatic test_invalid();
    restart(32'h0);
    press(1'b0, 4'b0110, 1'b0, 100, nf);
    checks++; if (nf !== 0) $display("FAIL multi_bit fires got %0d want 0", nf); else passed++;
    @(negedge clk); sel = 4'b0001;
    @(negedge clk);
    checks++; if (row_en !== 4'b0001) $display("FAIL multi_bit_ignored row_en got %b want 0001", row_en); else passed++;
    press(1'b0, 4'b0100, 1'b1, 100, nf);
    @(negedge clk); sel_error = 1'b0; sel = 4'b0001;
    @(negedge clk);
    checks++; if (row_en !== 4'b0001) $display("FAIL sel_error_ignored row_en got %b want 0001", row_en); else passed++;
    press(1'b0, 4'b0010, 1'b0, 100, nf);
    @(negedge clk); sel_error = 1'b1; sel = 4'b1000;
    @(negedge clk); @(negedge clk);
    checks++; if (row_en !== 4'b0010) $display("FAIL row_kept row_en got %b want 0010", row_en); else passed++;
    checks++; if (col_en !== 4'b0000) $display("FAIL row_kept col_en got %b want 0000", col_en); else passed++;
    press(1'b1, 4'b0100, 1'b1, 5, nf);
    checks++; if (nf !== 0) $display("FAIL col_err fires got %0d want 0", nf); else passed++;
    press(1'b1, 4'b0001, 1'b0, 100, nf);
    checks++; if (nf !== 1) $display("FAIL held_single fires got %0d want 1", nf); else passed++;
    checks++; if (shots !== 4'd1) $display("FAIL held_single shots got %0d want 1", shots); else passed++;
    checks++; if (last_result !== 2'b10) $display("FAIL unresolved last_result got %b want 10", last_result); else passed++;
    checks++; if (fault !== 1'b1) $display("FAIL unresolved fault got %b want 1", fault); else passed++;
  endtask

  task automatic test_win();
    int perm[16];
    int tmp, j;
    logic [31:0] g;
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i); tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    g = '0;
    for (int i = 0; i < 4; i++) g[2*perm[i] +: 2] = 2'b01;
    restart(g);
    shoot(perm[0] / 4, perm[0] % 4, 0, "win_s0");
    shoot(perm[4] / 4, perm[4] % 4, 0, "win_m0");
    shoot(perm[1] / 4, perm[1] % 4, 0, "win_s1");
    shoot(perm[2] / 4, perm[2] % 4, 0, "win_s2");
    shoot(perm[5] / 4, perm[5] % 4, 0, "win_m1");
    shoot(perm[3] / 4, perm[3] % 4, 0, "win_s3");
    shoot(perm[6] / 4, perm[6] % 4, 0, "win_after");
    checks++; if ({row_en, col_en} !== 8'd0) $display("FAIL done_enables got %b want 0", {row_en, col_en}); else passed++;
  endtask

  task automatic test_loss();
    restart(32'h0);
    for (int i = 0; i < 10; i++) shoot(i / 4, i % 4, i == 2, "loss_shot");
    shoot(2, 2, 0, "loss_after");
  endtask

  task automatic test_random();
    logic [31:0] g;
    int v;
    for (int gm = 0; gm < 3; gm++) begin
      for (int i = 0; i < 16; i++) begin
        v = $urandom_range(0, 9);
        g[2*i +: 2] = (v < 3) ? 2'b01 : (v < 8) ? 2'b00 : (v == 8) ? 2'b10 : 2'b11;
      end
      restart(g);
      for (int s = 0; s < 25; s++)
        shoot($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0, "random");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_hit();
    test_repeat();
    test_invalid();
    test_win();
    test_loss();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Turn controller for the 4x4 target grid.
- Converts operator actions into exactly one well-formed fire event per shot:
  - the row is armed and latched with one fire press;
  - the column is armed and latched with a second press.
- It then drives the cell row/column enables and a one-cycle fire strobe, waits for the cell to settle, and reads back the cell state.
- It tracks hits and shots, and ends the game on a win or when shots run out. Sits between the debounced inputs and the 16 cell instances and the display.

Parameters:
- MAX_SHOTS, 10, shots allowed before loss (1..15)
- SHIP_CELLS, 4, hits needed to win (1..16)
- SETTLE, 2, cycles between fire strobe and cell-state sampling (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fire_in  in  1  debounced fire button level
- sel  in  4  debounced row/column switch vector
- sel_error  in  1  switch-error flag from input checker
- n_row  in  1  0 = sel is a row, 1 = sel is a column
- cell_state  in  32  2 bits per cell; cell index = 4*row+col, bits [2i+1:2i]
- row_en  out  4  one-hot row enable to cells/display
- col_en  out  4  one-hot column enable to cells/display
- fire_out  out  1  one-cycle fire strobe to cells
- busy  out  1  high in FIRE/SETTLE/EVAL
- shots  out  4  shots taken
- hits  out  5  hits scored
- last_result  out  2  00 none, 01 hit, 10 miss, 11 repeat
- fault  out  1  sticky: cell did not resolve after a shot
- game_over  out  1  high in DONE
- won  out  1  high in DONE when hits reached SHIP_CELLS

Behaviour:
- Reset (async, active-low) forces:
  - state = ARM_ROW;
  - every output = 0;
  - latched row/col = 0;
  - fire_in edge register = 0.
- Fire event = rising edge of fire_in: registered previous value, so one event per press. Held level gives no repeats.
- Valid selection: sel_error = 0 and sel has exactly one bit set (checked internally, independent of sel_error).
- Cell encoding: 00 water, 01 ship, 10 hit, 11 miss.
- All outputs are registered and reflect the state entered one cycle after the causing event.
- ARM_ROW:
  - row_en = sel if valid and n_row = 0, else 0; col_en = 0.
  - Fire event with valid selection and n_row = 0: latch row, go to ARM_COL.
  - Any other fire event is ignored.
- ARM_COL:
  - row_en = latched row; col_en = sel if valid and n_row = 1, else 0.
  - Fire event with valid selection and n_row = 0: re-latch row, stay in ARM_COL.
  - Fire event with valid selection and n_row = 1: latch col, then inspect the target cell.
    - Target is 10 or 11: last_result = 11, shots unchanged, go to ARM_ROW.
    - Otherwise: go to FIRE.
  - Invalid selection: event ignored.
- FIRE: row_en/col_en = latched values; fire_out = 1 for exactly this cycle; go to SETTLE with counter = SETTLE.
- SETTLE: enables held; counter decrements; at 0 go to EVAL.
- EVAL (1 cycle): shots += 1.
  - Target = 10: hits += 1, last_result = 01.
  - Target = 11: last_result = 10.
  - Target = 00/01: last_result = 10 and fault = 1.
  - Next state:
    - If hits (post-update) = SHIP_CELLS: go to DONE with won = 1.
    - Else if shots = MAX_SHOTS: go to DONE with won = 0.
    - Else go to ARM_ROW.
  - Win takes priority when both conditions are true in the same cycle.
- DONE: enables 0, fire_out 0, game_over = 1; all fire events ignored; exit only via reset.
- Fire events during FIRE/SETTLE/EVAL are discarded, not queued.
- Counters saturate at their terminal values and never wrap.
- sel_error asserting in ARM_COL does not drop the latched row.
- Reset mid-SETTLE aborts the shot: no count and no result.

Decomposition:
- Shared package holds:
  - cell encodings (WATER, SHIP, HIT, MISS);
  - result codes;
  - state enum (ARM_ROW, ARM_COL, FIRE, SETTLE, EVAL, DONE).
- One sub-module, onehot_to_idx: 4-bit one-hot to 2-bit index plus valid flag. Used for row and column to form the cell index for the cell_state mux.

Test Plan:
- Reset low mid-operation -> all outputs 0, state ARM_ROW, shots = 0.
- n_row = 0, sel = 0010, fire press; then n_row = 1, sel = 0100, fire press; cell 6 returns 10 after fire -> fire_out pulses exactly once with row_en = 0010, col_en = 0100; SETTLE = 2 cycles later shots = 1, hits = 1, last_result = 01.
- Shot at a cell already 11 -> last_result = 11, no fire_out, shots unchanged, state ARM_ROW.
- sel = 0110 or sel_error = 1 with fire press, and fire_in held high 100 cycles -> no state change beyond a single event, no fire_out.
- Four hits in four shots (SHIP_CELLS = 4) -> game_over = 1, won = 1; further presses produce no fire_out.
- Ten misses -> game_over = 1, won = 0, shots = 10; cell stuck at 01 on one shot -> fault = 1 and stays set.
